// File: rtl/rope_electro_ctrl.sv
// rope_electro_ctrl: per-rope IDLE/WARN/LIVE/COOL sequencer with LFSR spawn arming and shock detection.
// Optional ELECTRO_CHAIN_EN: a rope leaving LIVE arms its same-side upper neighbour.
module rope_electro_ctrl #(
    parameter int ROPES = 6,
    parameter int WARN_FRAMES = 30,
    parameter int LIVE_FRAMES = 60,
    parameter int COOL_FRAMES = 90,
    parameter int SPAWN_FRAMES = 120,
    parameter int MAX_ACTIVE = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic                   enable,
    input  logic [1:0]             level,
    input  logic [ROPES-1:0]       monkeyCollision,
    output logic [ROPES-1:0][1:0]  electroStatus,
    output logic                   shockHit,
    output logic [2:0]             shockRope,
    output logic [3:0]             activeCount
);
    typedef enum logic [1:0] {IDLE = 2'b00, WARN = 2'b01, LIVE = 2'b10, COOL = 2'b11} phase_t;
    localparam int CW = 16;
    logic [ROPES-1:0][1:0]    state, state_nx;
    logic [ROPES-1:0][CW-1:0] cnt, cnt_nx;
    logic [15:0]              lfsr, spawn, spawn_nx, gap;
    logic [ROPES-1:0]         arm, hit;
    logic                     qual, shock_done, done_eff, fire;
    logic [2:0]               hit_idx;
    logic [3:0]               pop;

    assign electroStatus = state;
    assign qual = startOfFrame & enable;
    assign gap = 16'(SPAWN_FRAMES >> level) - 16'd1;
    assign done_eff = shock_done & ~startOfFrame;
    assign fire = enable & (|hit) & ~done_eff;

    // arming decisions use pre-frame state and the registered activeCount
    always_comb begin
        arm = '0;
        spawn_nx = spawn;
        if (qual) begin
            spawn_nx = (spawn == '0) ? gap : spawn - 16'd1;
            for (int i = 0; i < ROPES; i++)
                if (spawn == '0 && lfsr[2:0] == 3'(i) && state[i] == IDLE && int'(activeCount) < MAX_ACTIVE)
                    arm[i] = 1'b1;
`ifdef ELECTRO_CHAIN_EN
            for (int i = 0; i < ROPES-1; i++)
                if (state[i] == LIVE && cnt[i] == '0 && i+1 != ROPES/2)
                    arm[i+1] = 1'b1;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        for (int i = 0; i < ROPES; i++) begin
            if (!enable) begin
                state_nx[i] = IDLE;
                cnt_nx[i] = '0;
            end else if (startOfFrame) begin
                if (state[i] == IDLE) begin
                    if (arm[i]) begin
                        state_nx[i] = WARN;
                        cnt_nx[i] = CW'(WARN_FRAMES-1);
                    end
                end else if (cnt[i] != '0) begin
                    cnt_nx[i] = cnt[i] - CW'(1);
                end else begin
                    state_nx[i] = state[i] + 2'd1;
                    cnt_nx[i] = (state[i] == WARN) ? CW'(LIVE_FRAMES-1) :
                                (state[i] == LIVE) ? CW'(COOL_FRAMES-1) : '0;
                end
            end
        end
    end

    always_comb begin
        hit = '0;
        hit_idx = '0;
        pop = '0;
        for (int i = 0; i < ROPES; i++) begin
            hit[i] = monkeyCollision[i] && state[i] == LIVE;
            pop = pop + 4'((state[i] == WARN) || (state[i] == LIVE));
        end
        for (int i = ROPES-1; i >= 0; i--)
            if (hit[i]) hit_idx = 3'(i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= '0;
            cnt <= '0;
            spawn <= 16'(SPAWN_FRAMES);
            lfsr <= LFSR_SEED;
            activeCount <= '0;
            shockHit <= 1'b0;
            shockRope <= '0;
            shock_done <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            spawn <= spawn_nx;
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
            activeCount <= pop;
            shockHit <= fire;
            shockRope <= fire ? hit_idx : shockRope;
            shock_done <= done_eff | fire;
        end
    end
endmodule

// File: tb/tb_rope_electro_ctrl.sv
// tb_rope_electro_ctrl: random stimulus against an age-based behavioural model of the rope sequencer.
module tb_rope_electro_ctrl;
    localparam int R = 6, W = 2, L = 3, C = 1, S = 8, MA = 2;
    logic clk = 1'b0, reset = 1'b1, startOfFrame = 1'b0, enable = 1'b0;
    logic [1:0] level = 2'd0;
    logic [R-1:0] monkeyCollision = '0;
    logic [R-1:0][1:0] electroStatus;
    logic shockHit;
    logic [2:0] shockRope;
    logic [3:0] activeCount;
    int total = 0, bad = 0;
    int age[R];
    int spawn, m_ac, m_rope, since_sof = 0;
    bit m_hit, m_done;
    logic [15:0] m_lfsr;

    rope_electro_ctrl #(.ROPES(R), .WARN_FRAMES(W), .LIVE_FRAMES(L), .COOL_FRAMES(C),
                        .SPAWN_FRAMES(S), .MAX_ACTIVE(MA), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .enable(enable), .level(level),
        .monkeyCollision(monkeyCollision), .electroStatus(electroStatus), .shockHit(shockHit),
        .shockRope(shockRope), .activeCount(activeCount));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // age = frames since arming, -1 when idle; phase follows from cumulative durations
    function automatic int phase(input int a);
        return a < 0 ? 0 : a < W ? 1 : a < W+L ? 2 : a < W+L+C ? 3 : 0;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] v = '0;
        for (int i = 0; i < R; i++) v[2*i +: 2] = 2'(phase(age[i]));
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < R; i++) age[i] = -1;
        spawn = S; m_ac = 0; m_rope = 0; m_hit = 0; m_done = 0; m_lfsr = 16'hACE1;
    endtask

    task automatic model_step();
        int pre[R];
        int pre_age[R];
        int lo, c, tgt, n;
        lo = -1; n = 0; tgt = -1;
        for (int i = 0; i < R; i++) begin
            pre[i] = phase(age[i]);
            pre_age[i] = age[i];
            if (pre[i] == 1 || pre[i] == 2) n++;
        end
        for (int i = R-1; i >= 0; i--) if (monkeyCollision[i] && pre[i] == 2) lo = i;
        if (startOfFrame) m_done = 0;
        m_hit = enable && lo >= 0 && !m_done;
        if (m_hit) begin m_rope = lo; m_done = 1; end
        if (!enable) begin
            for (int i = 0; i < R; i++) age[i] = -1;
        end else if (startOfFrame) begin
            c = int'(m_lfsr[2:0]);
            if (spawn == 0) begin
                if (c < R && pre[c] == 0 && m_ac < MA) tgt = c;
                spawn = (S >> level) - 1;
            end else spawn--;
            for (int i = 0; i < R; i++) if (age[i] >= 0) begin
                age[i]++;
                if (age[i] >= W+L+C) age[i] = -1;
            end
            if (tgt >= 0) age[tgt] = 0;
`ifdef ELECTRO_CHAIN_EN
            for (int i = 0; i < R-1; i++)
                if (pre_age[i] == W+L-1 && pre[i+1] == 0 && i+1 != R/2) age[i+1] = 0;
`endif
        end
        m_ac = n;
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    endtask

    task automatic check_all();
        chk("status", 32'(electroStatus), exp_status());
        chk("shockHit", 32'(shockHit), 32'(m_hit));
        chk("shockRope", 32'(shockRope), 32'(m_rope));
        chk("activeCount", 32'(activeCount), 32'(m_ac));
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b0;
        enable = 1'b1;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            startOfFrame = since_sof >= 2 && $urandom_range(0, 2) == 0;
            since_sof = startOfFrame ? 0 : since_sof + 1;
            enable = enable ? ($urandom_range(0, 149) != 0) : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) level = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                monkeyCollision = $urandom_range(0, 1) ? R'($urandom) : '0;
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
            if (cyc % 1000 == 999) begin
                #2 reset = 1'b1;
                #1 model_reset();
                check_all();
                @(negedge clk);
                reset = 1'b0;
                check_all();
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rope_electro_ctrl.md
Name: rope_electro_ctrl

Overview:
Per-rope electrification sequencer that sits directly upstream of the rope display stage and drives its 2-bit-per-rope electroStatus bus. Once per frame it arms ropes pseudo-randomly and steps each armed rope through warning, live and cooldown phases. While a rope is live, it qualifies the per-rope monkeyCollision flags into a single registered shock event for the game-control FSM.

Parameters:
ROPES, 6, number of ropes; must match the display stage (valid range 2..8)
WARN_FRAMES, 30, frames a rope spends in WARN
LIVE_FRAMES, 60, frames a rope spends in LIVE
COOL_FRAMES, 90, frames a rope spends in COOL before returning to IDLE
SPAWN_FRAMES, 120, base frame gap between arming attempts
MAX_ACTIVE, 2, maximum number of ropes in WARN or LIVE at one time
LFSR_SEED, 16'hACE1, nonzero reset value of the LFSR

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
startOfFrame  in  1  one-cycle pulse per video frame
enable  in  1  game running; low forces all ropes to IDLE
level  in  2  difficulty level; spawn gap = SPAWN_FRAMES >> level
monkeyCollision  in  ROPES  per-rope monkey/rope pixel overlap
electroStatus  out  ROPES x 2  per-rope phase: 00 IDLE, 01 WARN, 10 LIVE, 11 COOL
shockHit  out  1  one-cycle pulse: monkey touched a LIVE rope
shockRope  out  3  index of the rope that caused the last shockHit
activeCount  out  4  number of ropes currently in WARN or LIVE

Behaviour:
- Reset (asynchronous, active-high):
  - All electroStatus = 00; shockHit = 0; shockRope = 0; activeCount = 0.
  - All per-rope frame counters = 0; spawn timer = SPAWN_FRAMES; LFSR = LFSR_SEED.
- LFSR:
  - 16-bit Galois LFSR, taps 16,14,13,11 (mask 16'hB400).
  - Advances once per clock whenever reset is low, independent of enable.
- Per-rope FSM (IDLE -> WARN -> LIVE -> COOL -> IDLE):
  - State and counter change only on a cycle where startOfFrame=1 and enable=1.
  - On entering WARN, LIVE or COOL, the counter loads that phase's *_FRAMES-1.
  - Each qualifying frame the counter decrements; when it is 0 at a frame, the rope advances to the next phase.
  - Each phase therefore lasts exactly its *_FRAMES frames.
  - The electroStatus register is the state register itself, so there is zero latency from a state change to the output.
- Arming (evaluated only on qualifying frames):
  - The spawn timer decrements each qualifying frame.
  - When the spawn timer is 0:
    - Candidate index c = LFSR[2:0].
    - The rope is armed (IDLE -> WARN) only if c < ROPES, rope c is IDLE, and activeCount < MAX_ACTIVE.
    - The spawn timer reloads to (SPAWN_FRAMES >> level) - 1 whether or not the arm succeeded (an attempt is consumed).
  - A rope that finishes COOL at the same frame it is chosen is not armed, because the check uses pre-frame state.
  - At most one rope is armed per frame.
- activeCount: registered population count of ropes in WARN or LIVE, updated the cycle after any state change.
- Shock detection:
  - Combinational hit vector = monkeyCollision & (state == LIVE), evaluated against registered, pre-transition state.
  - On the first cycle within a frame that the hit vector is nonzero:
    - shockHit pulses for 1 cycle, registered (1-cycle latency from monkeyCollision).
    - shockRope = lowest set index.
  - Further hits are suppressed until the next startOfFrame; startOfFrame re-arms detection in the same cycle.
  - shockRope holds its value between hits.
- enable low:
  - On the next clock, all ropes go to IDLE and counters clear; the spawn timer holds its value.
  - shockHit is forced to 0.
  - On return to enable high, operation resumes with all ropes IDLE.
- Reset mid-phase: immediate asynchronous return to reset values; no partial frame is counted.

Optional Feature:
ELECTRO_CHAIN_EN
- Defined: when rope i leaves LIVE for COOL, rope i+1 (if i+1 < ROPES, i+1 is on the same side, i.e. not crossing the ROPES/2 boundary, and i+1 is IDLE) is armed into WARN on the same frame. This chain arm ignores MAX_ACTIVE and does not consume the spawn timer. If a random arm selects the same rope on that frame, only one transition occurs.
- Undefined: no chaining; ropes are armed only by the spawn timer.

Test Plan:
- Reset check: assert reset mid-frame with rope 2 LIVE -> all electroStatus=00, activeCount=0, shockHit=0 immediately, before the next clock edge.
- Phase timing: WARN=2, LIVE=3, COOL=1, force arm of rope 0 -> electroStatus[0] reads 01 for 2 frames, 10 for 3 frames, 11 for 1 frame, then 00.
- Arming limit: MAX_ACTIVE=1, rope 1 in WARN, spawn timer expires selecting rope 4 -> rope 4 stays 00, spawn timer reloads.
- Shock event: rope 3 LIVE, monkeyCollision=6'b001000 held for 5 cycles -> exactly one shockHit pulse, 1 cycle after the input rises, shockRope=3. Repeat on the next frame -> second pulse.
- Non-LIVE collision: rope 5 in WARN, monkeyCollision[5]=1 -> no shockHit.
- enable drop: enable=0 with two ropes active -> all 00 on the next clock, activeCount=0 one cycle later. With ELECTRO_CHAIN_EN defined: rope 0 LIVE->COOL -> rope 1 enters WARN on the same frame; rope 2 LIVE->COOL with ROPES=6 -> rope 3 is unaffected.
